counter_display: RTL and testbench
==================================

# counter_display

Parametrised counter-plus-display block for the FPGA board: a prescaled up/down counter with synchronous load drives the LED bank directly and a time-multiplexed multi-digit hex 7-segment display. It generalises the fixed 8-bit free-running counter and single-digit segment decoder into one block with configurable width, step rate, digit count, direction and load. It sits under the top level, with its control inputs driven from board switches or Raspberry Pi GPIO.

## Interface
- WIDTH, 8: counter width in bits; must satisfy 4*DIGITS >= WIDTH.
- DIGITS, 2: number of scanned hex digits, minimum 1.
- PRESCALE, 50_000_000: clock cycles per count step, minimum 1.
- SCAN_DIV, 50_000: clock cycles each digit stays selected, minimum 1.
- in_clk  in  1  system clock.
- in_rst  in  1  reset; asynchronous, active-high.
- in_en  in  1  count enable; when low, the prescaler and counter hold.
- in_up  in  1  direction: 1 counts up, 0 counts down.
- in_load  in  1  synchronous load strobe.
- in_load_val  in  WIDTH  value captured on in_load.
- out_led  out  WIDTH  current count value.
- out_seg  out  8  segment pattern, active-high; bit0..6 = a..g, bit7 = dp.
- out_dig  out  DIGITS  one-hot digit select, active-high.
- out_wrap  out  1  one-cycle pulse on counter wrap-around.

## Operation
- Prescaler:
  - counts 0..PRESCALE-1 while in_en = 1.
  - Asserts an internal step in the cycle it equals PRESCALE-1, then returns to 0.
  - PRESCALE = 1 gives a step every enabled cycle.
- Counter update priority, in this order:
  - in_load: count <= in_load_val and prescaler <= 0, regardless of in_en.
  - step with in_up = 1: count + 1 modulo 2^WIDTH.
  - step with in_up = 0: count - 1 modulo 2^WIDTH.
  - otherwise the count holds.
- Wrap detection:
  - out_wrap = 1 for exactly the cycle after a step takes the count from 2^WIDTH-1 to 0 (up), or from 0 to 2^WIDTH-1 (down).
  - A load never raises out_wrap.
- Scan:
  - A scan counter runs 0..SCAN_DIV-1 continuously and is independent of in_en.
  - At SCAN_DIV-1, the digit index advances to index+1, wrapping from DIGITS-1 to 0.
- Display:
  - The count is zero-extended to 4*DIGITS bits.
  - Digit i shows nibble i, with digit 0 as the least significant nibble.
  - Hex glyphs cover 0-F.
  - dp (bit7) = ~in_up, i.e. dp is lit while counting down.
- Reset values: count 0, prescaler 0, scan counter 0, digit index 0, out_led 0, out_dig = 1 (digit 0), out_seg = glyph "0" with dp clear (8'h3F), out_wrap 0.
- Reset mid-operation clears all state immediately; no pending step or load survives.

## Timing
- out_led is the count register itself. A step or load is visible on out_led at the clock edge that applies it.
- out_seg and out_dig are registered. They reflect the count and digit index one cycle after those change, and they always change together, so a glyph is never shown on the wrong digit.
- Simultaneous in_load and step: the load wins, the step is discarded, and the prescaler restarts at 0.
- in_en deasserted mid-period: the prescaler freezes at its current value and resumes from there.
- in_up changing mid-period affects only the next step; the prescaler is not reset.

## Structure
- Package disp_pkg holds:
  - the 16 glyph constants SEG_0..SEG_F (8-bit, active-high, dp clear);
  - the dp bit index constant;
  - a hex-to-segment function.
- Sub-module seg_decode: a combinational 4-bit to 8-bit decoder built on disp_pkg. One instance feeds the out_seg register, driven by a mux selecting the active nibble.
- Elaboration-time check that 4*DIGITS >= WIDTH, PRESCALE >= 1 and SCAN_DIV >= 1.

## Test plan
- Reset mid-count, at WIDTH=8, PRESCALE=4, count=8'h37: assert in_rst asynchronously -> out_led=0, out_dig=2'b01, out_seg=8'h3F, out_wrap=0, all without waiting for a clock edge.
- Up-count wrap, at WIDTH=8, PRESCALE=4: load 8'hFE, then en=1, up=1 -> count is FF after 4 cycles and 00 after 8; out_wrap pulses once, for exactly one cycle, at the 00 step.
- Down-count and dp: load 8'h01, up=0 -> 00 then FF; one out_wrap pulse; out_seg[7]=1 on every digit.
- Load/step collision: in_load with in_load_val=8'h5A asserted in the step cycle -> out_led=5A, not 5A±1; the next step occurs PRESCALE cycles later.
- Scan, at DIGITS=2, SCAN_DIV=3, count=8'hA7:
  - out_dig alternates 01/10, 3 cycles each;
  - out_seg shows 8'h07 ("7") with 01 and 8'h77 ("A") with 10;
  - seg/dig change on the same edge.
- Enable hold: in_en dropped at prescaler value 2 for 10 cycles -> count unchanged; after re-enable, the step occurs PRESCALE-2 cycles later.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared 7-segment glyph table and hex decoder for the counter display.
// Segment bits are active-high: bit0..6 = a..g, bit7 = decimal point.
package disp_pkg;

  localparam int DP_BIT = 7;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble-to-glyph decoder with an explicit decimal-point input.
module seg_decode
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] seg
);

  // NOTE: every bit is assigned on every pass through always_comb, so no latch can form.
  always_comb begin
    seg         = hex_to_seg(hex);
    seg[DP_BIT] = dp;
  end

endmodule

// File: rtl/counter_display.sv
// Prescaled up/down counter with synchronous load, driving the LED bank and a
// time-multiplexed hex 7-segment display with registered segment/digit outputs.
module counter_display
  import disp_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_en,
  input  logic              in_up,
  input  logic              in_load,
  input  logic [WIDTH-1:0]  in_load_val,
  output logic [WIDTH-1:0]  out_led,
  output logic [7:0]        out_seg,
  output logic [DIGITS-1:0] out_dig,
  output logic              out_wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (4 * DIGITS < WIDTH || PRESCALE < 1 || SCAN_DIV < 1) begin : g_param_check
    $error("counter_display: need 4*DIGITS >= WIDTH, PRESCALE >= 1, SCAN_DIV >= 1");
  end

  logic [PW-1:0]         pre;
  logic [SW-1:0]         scan_cnt;
  logic [DW-1:0]         dig_idx;
  logic                  step;
  logic [4*DIGITS-1:0]   padded;
  logic [3:0]            nibble;
  logic [7:0]            seg_next;

  assign step = in_en && (pre == PW'(PRESCALE - 1));

  // Load beats a coincident step and restarts the prescaler.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_led  <= '0;
      pre      <= '0;
      out_wrap <= 1'b0;
    end else if (in_load) begin
      out_led  <= in_load_val;
      pre      <= '0;
      out_wrap <= 1'b0;
    end else begin
      out_wrap <= step && (in_up ? (&out_led) : ~(|out_led));
      if (in_en)
        pre <= step ? '0 : pre + PW'(1);
      if (step)
        out_led <= in_up ? out_led + WIDTH'(1) : out_led - WIDTH'(1);
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == DW'(DIGITS - 1)) ? '0 : dig_idx + DW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign padded = (4 * DIGITS)'(out_led);

  always_comb begin
    nibble = '0;
    for (int i = 0; i < DIGITS; i++)
      if (dig_idx == DW'(i))
        nibble = padded[4*i +: 4];
  end

  seg_decode u_seg_decode (
    .hex (nibble),
    .dp  (~in_up),
    .seg (seg_next)
  );

  // Glyph and digit select share one register stage so they always switch together.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_seg <= SEG_0;
      out_dig <= DIGITS'(1);
    end else begin
      out_seg <= seg_next;
      out_dig <= DIGITS'(1) << dig_idx;
    end
  end

endmodule

// File: tb/tb_counter_display.sv
// Directed plus randomized bench for counter_display against a cycle-level
// behavioural model built from phase counting and absolute scan time.
module tb_counter_display;

  localparam int W = 8;
  localparam int D = 2;
  localparam int P = 4;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] out_led;
  logic [7:0]   out_seg;
  logic [D-1:0] out_dig;
  logic         out_wrap;

  int vectors     = 0;
  int miscompares = 0;

  int           m_count;
  int           m_phase;
  int           m_ticks;
  logic         m_wrap;
  logic [D-1:0] m_dig;
  logic [7:0]   m_seg;
  int           wraps;

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  counter_display #(.WIDTH(W), .DIGITS(D), .PRESCALE(P), .SCAN_DIV(S)) dut (
    .in_clk      (clk),
    .in_rst      (rst),
    .in_en       (en),
    .in_up       (up),
    .in_load     (load),
    .in_load_val (load_val),
    .out_led     (out_led),
    .out_seg     (out_seg),
    .out_dig     (out_dig),
    .out_wrap    (out_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_phase = 0;
    m_ticks = 0;
    m_wrap  = 1'b0;
    m_dig   = D'(1);
    m_seg   = 8'h3F;
  endtask

  // Display shows the state held before this edge; the digit comes from elapsed time.
  task automatic model_edge();
    int idx;
    idx      = (m_ticks / S) % D;
    m_dig    = '0;
    m_dig[idx] = 1'b1;
    m_seg    = glyph[(m_count >> (4 * idx)) & 15] | (up ? 8'h00 : 8'h80);
    m_ticks++;
    m_wrap   = 1'b0;
    if (load) begin
      m_count = int'(load_val);
      m_phase = 0;
    end else if (en) begin
      m_phase++;
      if (m_phase == P) begin
        m_phase = 0;
        m_wrap  = up ? (m_count == 255) : (m_count == 0);
        m_count = (m_count + (up ? 1 : -1) + 256) % 256;
      end
    end
  endtask

  task automatic check_all();
    check("led",  32'(out_led),  32'(m_count));
    check("wrap", 32'(out_wrap), 32'(m_wrap));
    check("dig",  32'(out_dig),  32'(m_dig));
    check("seg",  32'(out_seg),  32'(m_seg));
  endtask

  task automatic tick(input logic e, input logic u, input logic l, input logic [W-1:0] v);
    en       = e;
    up       = u;
    load     = l;
    load_val = v;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Asynchronous reset in the middle of counting from 8'h37.
    tick(1'b0, 1'b1, 1'b1, 8'h37);
    repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
    check("pre_reset_led", 32'(out_led), 32'h37);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Up-count across FF -> 00.
    tick(1'b0, 1'b1, 1'b1, 8'hFE);
    wraps = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b0, '0);
      if (out_wrap) wraps++;
      if (i == 3) check("up_ff", 32'(out_led), 32'hFF);
      if (i == 7) check("up_00", 32'(out_led), 32'h00);
      if (i == 7) check("up_wrap_at_00", 32'(out_wrap), 32'h1);
    end
    check("up_wrap_pulses", 32'(wraps), 32'd1);

    // Down-count across 00 -> FF with dp lit.
    tick(1'b0, 1'b0, 1'b1, 8'h01);
    wraps = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0, '0);
      if (out_wrap) wraps++;
      check("down_dp", 32'(out_seg[7]), 32'h1);
    end
    check("down_wrap_pulses", 32'(wraps), 32'd1);
    check("down_final", 32'(out_led), 32'hFF);

    // Load arriving in the step cycle wins and restarts the prescaler.
    tick(1'b0, 1'b1, 1'b1, 8'h00);
    repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 1'b1, 8'h5A);
    check("collision_led", 32'(out_led), 32'h5A);
    repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
    check("collision_hold", 32'(out_led), 32'h5A);
    tick(1'b1, 1'b1, 1'b0, '0);
    check("collision_next_step", 32'(out_led), 32'h5B);

    // Scan of 8'hA7 over two digits.
    tick(1'b0, 1'b1, 1'b1, 8'hA7);
    repeat (12) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      check("scan_pair", 32'(out_seg), (out_dig == 2'b01) ? 32'h07 : 32'h77);
    end

    // Enable dropped with the prescaler at 2.
    tick(1'b0, 1'b1, 1'b1, 8'h10);
    repeat (2) tick(1'b1, 1'b1, 1'b0, '0);
    repeat (10) tick(1'b0, 1'b1, 1'b0, '0);
    check("hold_led", 32'(out_led), 32'h10);
    tick(1'b1, 1'b1, 1'b0, '0);
    check("hold_resume_1", 32'(out_led), 32'h10);
    tick(1'b1, 1'b1, 1'b0, '0);
    check("hold_resume_2", 32'(out_led), 32'h11);

    // Randomized traffic.
    repeat (400)
      tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, W'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
